keypad_alu_seq: RTL and testbench
=================================

// Module: keypad_alu_seq
// PURPOSE
//  Parametrised keypad-driven signed calculator datapath: decodes 8-bit key codes strobed by validate,
//  builds two signed decimal operands A/B digit by digit, and continuously produces A+B or A-B.
//  Sits between the keypad decoder and the BCD display driver; ON gates the display.
//  Successor block: one clock domain, synchronised validate strobe, DIGITS-digit operands, true sign handling.
// PARAMETERS
//  DIGITS      2      max decimal digits per operand; extra digits ignored
//  W           8      operand magnitude width; 10**DIGITS-1 <= 2**W-1 required
//  K_ONOFF     18     key code: power toggle
//  K_DEF_A     15     key code: start entry of A
//  K_DEF_B     19     key code: start entry of B
//  K_CLEAR     16     key code: clear all
//  K_SIGN      12     key code: toggle sign of operand being entered
//  K_SUM       26     key code: select add
//  K_MINUS     30     key code: select subtract
// PORTS
//  CLOCK_50    in   1      system clock, 50 MHz, all flops on rising edge
//  RESET_N     in   1      asynchronous active-low reset
//  validate    in   1      key strobe from keypad, asynchronous to CLOCK_50, active high
//  data        in   8      key code; digits 0..9 are codes 0..9
//  out_A       out  W+1    operand A, two's complement
//  out_B       out  W+1    operand B, two's complement
//  value       out  W+2    result A+B or A-B, two's complement, registered
//  ON          out  1      calculator powered; display enable
//  mode        out  2      FSM state: 0 OFF, 1 IDLE, 2 ENTER_A, 3 ENTER_B
//  op_sub      out  1      0 = add selected, 1 = subtract selected
// BEHAVIOUR
//  Reset (async, RESET_N=0): mode OFF, ON 0, out_A/out_B/value 0, op_sub 0, digit counts 0, signs +.
//  Strobe: v1<=validate, v2<=v1, v3<=v2; key_stb = v2 & ~v3. v1/v2 reset to 0, v3 reset to 1, so validate
//   held high across reset release yields no key. One key per validate rising edge; held validate = one key.
//  Data sampled on the edge ending the key_stb cycle (3rd CLOCK_50 edge after validate rise); data stable
//   while validate high; validate high >= 3 clocks, low >= 3 clocks between keys.
//  Latency: out_A/out_B/mode/op_sub/ON update on that 3rd edge; value updates 1 edge later (4th).
//  value <= op_sub ? (A - B) : (A + B) every clock, sign-extended to W+2; never overflows.
//  FSM, evaluated only when key_stb=1 (unlisted codes ignored in every state):
//   OFF:      K_ONOFF -> IDLE, ON=1, full clear; all other keys ignored.
//   any on:   K_ONOFF -> OFF, ON=0, full clear.
//             K_CLEAR -> IDLE, full clear (A=B=0, signs +, counts 0, op_sub=0).
//             K_DEF_A -> ENTER_A, magA=0, signA=+, cntA=0.  K_DEF_B -> ENTER_B likewise for B.
//             K_SUM -> IDLE, op_sub=0.  K_MINUS -> IDLE, op_sub=1. Operands kept.
//   ENTER_X:  digit d (0..9): if cntX<DIGITS then magX<=magX*10+d, cntX++; else ignored.
//             K_SIGN: signX toggles, magX unchanged; legal before/between digits.
//   IDLE:     digits and K_SIGN ignored.
//  out_X = signX ? -magX : magX; magnitude 0 with sign - outputs 0.
//  Leading zeros count as digits (0,7 -> 7 uses 2 of DIGITS).
//  magX*10 uses (magX<<3)+(magX<<1) in W+4 bits, truncated to W; safe by W/DIGITS constraint.
//  RESET_N low mid-entry: immediate clear to reset values, partial entry discarded.
// TESTING
//  1 Reset; key 5; key K_SUM -> ON=0, mode=0, out_A=0; key K_ONOFF -> ON=1, mode=1 on 3rd clock edge.
//  2 On; K_DEF_A,4,2,7; K_DEF_B,1,5 -> out_A=42 (7 ignored), out_B=15, value=57 one clock after out_B.
//  3 From 2: K_MINUS -> value=27; K_DEF_B,K_SIGN,1,5 -> out_B=-15, value=57; K_SUM -> value=27.
//  4 K_DEF_A,9,9,K_SIGN; K_DEF_B,9,9,K_SIGN; K_SUM -> out_A=-99, out_B=-99, value=-198 (10'h33A).
//  5 validate held high 100 clocks with data=3 in ENTER_A -> magA=3 only; RESET_N pulse low during
//    entry with validate high -> all outputs 0 immediately, mode=0, no key after release.
//  6 K_DEF_A,0,K_SIGN -> out_A=0; then K_CLEAR -> A=B=0, op_sub=0, mode=1, ON stays 1.

Source files
------------

// File: rtl/keypad_alu_seq_if.sv
// Keypad calculator bus: key strobe/code in, operands, result and status out.
interface keypad_alu_seq_if #(
  parameter int unsigned W = 8
) ();
  logic              validate;
  logic [7:0]        data;
  logic [W:0]        out_A;
  logic [W:0]        out_B;
  logic [W+1:0]      value;
  logic              ON;
  logic [1:0]        mode;
  logic              op_sub;

  modport master (
    output validate, data,
    input  out_A, out_B, value, ON, mode, op_sub
  );

  modport slave (
    input  validate, data,
    output out_A, out_B, value, ON, mode, op_sub
  );
endinterface

// File: rtl/keypad_alu_seq.sv
// Keypad-driven signed calculator: builds decimal operands A/B from key codes and
// continuously registers A+B or A-B for the display driver.
module keypad_alu_seq #(
  parameter int unsigned DIGITS  = 2,
  parameter int unsigned W       = 8,
  parameter logic [7:0]  K_ONOFF = 8'd18,
  parameter logic [7:0]  K_DEF_A = 8'd15,
  parameter logic [7:0]  K_DEF_B = 8'd19,
  parameter logic [7:0]  K_CLEAR = 8'd16,
  parameter logic [7:0]  K_SIGN  = 8'd12,
  parameter logic [7:0]  K_SUM   = 8'd26,
  parameter logic [7:0]  K_MINUS = 8'd30
) (
  input logic              CLOCK_50,
  input logic              RESET_N,
  keypad_alu_seq_if.slave  bus
);

  localparam int unsigned CntW = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {StOff = 2'd0, StIdle = 2'd1, StEnterA = 2'd2, StEnterB = 2'd3} state_e;

  state_e          state_q, state_d;
  logic            v1_q, v2_q, v3_q;
  logic [1:0]      prime_q;
  logic [W-1:0]    mag_a_q, mag_a_d, mag_b_q, mag_b_d;
  logic            sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [CntW-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic            op_sub_q, op_sub_d;
  logic [W+1:0]    value_q, value_d;
  logic [W:0]      out_a, out_b, ext_a, ext_b;

  logic key_stb, is_digit;
  logic clr_all, clr_a, clr_b, dig_a, dig_b, tog_a, tog_b, set_add, set_sub;

  function automatic logic [W-1:0] mac10(input logic [W-1:0] m, input logic [3:0] d);
    logic [W+3:0] t;
    t = ({4'b0000, m} << 3) + ({4'b0000, m} << 1) + {{W{1'b0}}, d};
    return t[W-1:0];
  endfunction

  // v3 is held at 1 until v2 carries a real sample, so a validate held across reset
  // release never looks like a fresh rising edge.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b1;
      prime_q <= 2'b00;
    end else begin
      v1_q    <= bus.validate;
      v2_q    <= v1_q;
      v3_q    <= prime_q[1] ? v2_q : 1'b1;
      prime_q <= {prime_q[0], 1'b1};
    end
  end

  assign key_stb  = v2_q & ~v3_q;
  assign is_digit = (bus.data < 8'd10);

  // FSM state register
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) state_q <= StOff;
    else          state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (key_stb) begin
      if (state_q == StOff) begin
        if (bus.data == K_ONOFF) state_d = StIdle;
      end else begin
        case (bus.data)
          K_ONOFF: state_d = StOff;
          K_CLEAR: state_d = StIdle;
          K_SUM:   state_d = StIdle;
          K_MINUS: state_d = StIdle;
          K_DEF_A: state_d = StEnterA;
          K_DEF_B: state_d = StEnterB;
          default: state_d = state_q;
        endcase
      end
    end
  end

  // FSM outputs: datapath control strobes
  always_comb begin
    clr_all = 1'b0;
    clr_a   = 1'b0;
    clr_b   = 1'b0;
    dig_a   = 1'b0;
    dig_b   = 1'b0;
    tog_a   = 1'b0;
    tog_b   = 1'b0;
    set_add = 1'b0;
    set_sub = 1'b0;
    if (key_stb) begin
      if (state_q == StOff) begin
        clr_all = (bus.data == K_ONOFF);
      end else begin
        case (bus.data)
          K_ONOFF: clr_all = 1'b1;
          K_CLEAR: clr_all = 1'b1;
          K_DEF_A: clr_a   = 1'b1;
          K_DEF_B: clr_b   = 1'b1;
          K_SUM:   set_add = 1'b1;
          K_MINUS: set_sub = 1'b1;
          K_SIGN: begin
            tog_a = (state_q == StEnterA);
            tog_b = (state_q == StEnterB);
          end
          default: begin
            dig_a = is_digit && (state_q == StEnterA) && (cnt_a_q < CntW'(DIGITS));
            dig_b = is_digit && (state_q == StEnterB) && (cnt_b_q < CntW'(DIGITS));
          end
        endcase
      end
    end
  end

  always_comb begin
    mag_a_d  = mag_a_q;
    sign_a_d = sign_a_q;
    cnt_a_d  = cnt_a_q;
    mag_b_d  = mag_b_q;
    sign_b_d = sign_b_q;
    cnt_b_d  = cnt_b_q;
    op_sub_d = op_sub_q;
    if (clr_all || clr_a) begin
      mag_a_d  = '0;
      sign_a_d = 1'b0;
      cnt_a_d  = '0;
    end else if (dig_a) begin
      mag_a_d = mac10(mag_a_q, bus.data[3:0]);
      cnt_a_d = cnt_a_q + CntW'(1);
    end else if (tog_a) begin
      sign_a_d = ~sign_a_q;
    end
    if (clr_all || clr_b) begin
      mag_b_d  = '0;
      sign_b_d = 1'b0;
      cnt_b_d  = '0;
    end else if (dig_b) begin
      mag_b_d = mac10(mag_b_q, bus.data[3:0]);
      cnt_b_d = cnt_b_q + CntW'(1);
    end else if (tog_b) begin
      sign_b_d = ~sign_b_q;
    end
    if (clr_all || set_add) op_sub_d = 1'b0;
    else if (set_sub)       op_sub_d = 1'b1;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      mag_a_q  <= '0;
      sign_a_q <= 1'b0;
      cnt_a_q  <= '0;
      mag_b_q  <= '0;
      sign_b_q <= 1'b0;
      cnt_b_q  <= '0;
      op_sub_q <= 1'b0;
      value_q  <= '0;
    end else begin
      mag_a_q  <= mag_a_d;
      sign_a_q <= sign_a_d;
      cnt_a_q  <= cnt_a_d;
      mag_b_q  <= mag_b_d;
      sign_b_q <= sign_b_d;
      cnt_b_q  <= cnt_b_d;
      op_sub_q <= op_sub_d;
      value_q  <= value_d;
    end
  end

  // Negating a zero magnitude yields zero, so "-0" never reaches the outputs.
  assign ext_a   = {1'b0, mag_a_q};
  assign ext_b   = {1'b0, mag_b_q};
  assign out_a   = sign_a_q ? ({(W+1){1'b0}} - ext_a) : ext_a;
  assign out_b   = sign_b_q ? ({(W+1){1'b0}} - ext_b) : ext_b;
  assign value_d = op_sub_q ? ({out_a[W], out_a} - {out_b[W], out_b})
                            : ({out_a[W], out_a} + {out_b[W], out_b});

  assign bus.out_A  = out_a;
  assign bus.out_B  = out_b;
  assign bus.value  = value_q;
  assign bus.ON     = (state_q != StOff);
  assign bus.mode   = state_q;
  assign bus.op_sub = op_sub_q;

endmodule

// File: tb/tb_keypad_alu_seq.sv
// Self-checking bench for keypad_alu_seq: key table with a scoreboard queue, plus
// hand-written latency, held-strobe and mid-entry reset sequences.
module tb_keypad_alu_seq;

  localparam int unsigned W = 8;

  typedef struct {
    logic [7:0] key;
    int         mode;
    int         on;
    int         a;
    int         b;
    int         val;
    int         sub;
  } vec_t;

  logic CLOCK_50 = 1'b0;
  logic RESET_N  = 1'b0;

  keypad_alu_seq_if #(.W(W)) bus ();

  keypad_alu_seq #(.DIGITS(2), .W(W)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .bus      (bus)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int   n_cmp = 0;
  int   n_err = 0;
  vec_t vecs[$];
  vec_t sb[$];
  vec_t e;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int sa();
    return int'($signed(bus.out_A));
  endfunction
  function automatic int sbv();
    return int'($signed(bus.out_B));
  endfunction
  function automatic int sv();
    return int'($signed(bus.value));
  endfunction

  task automatic press(input logic [7:0] k);
    @(negedge CLOCK_50);
    bus.data     = k;
    bus.validate = 1'b1;
    repeat (4) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    bus.validate = 1'b0;
    repeat (4) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
  endtask

  task automatic add(input logic [7:0] k, input int m, input int o, input int a, input int b,
                     input int v, input int s);
    vec_t t;
    t.key = k; t.mode = m; t.on = o; t.a = a; t.b = b; t.val = v; t.sub = s;
    vecs.push_back(t);
  endtask

  initial begin
    //   key    mode on  A    B    value sub
    add(8'd5,  0, 0,   0,   0,    0, 0);
    add(8'd26, 0, 0,   0,   0,    0, 0);
    add(8'd18, 1, 1,   0,   0,    0, 0);
    add(8'd15, 2, 1,   0,   0,    0, 0);
    add(8'd4,  2, 1,   4,   0,    4, 0);
    add(8'd2,  2, 1,  42,   0,   42, 0);
    add(8'd7,  2, 1,  42,   0,   42, 0);
    add(8'd19, 3, 1,  42,   0,   42, 0);
    add(8'd1,  3, 1,  42,   1,   43, 0);
    add(8'd5,  3, 1,  42,  15,   57, 0);
    add(8'd30, 1, 1,  42,  15,   27, 1);
    add(8'd19, 3, 1,  42,   0,   42, 1);
    add(8'd12, 3, 1,  42,   0,   42, 1);
    add(8'd1,  3, 1,  42,  -1,   43, 1);
    add(8'd5,  3, 1,  42, -15,   57, 1);
    add(8'd26, 1, 1,  42, -15,   27, 0);
    add(8'd15, 2, 1,   0, -15,  -15, 0);
    add(8'd9,  2, 1,   9, -15,   -6, 0);
    add(8'd9,  2, 1,  99, -15,   84, 0);
    add(8'd12, 2, 1, -99, -15, -114, 0);
    add(8'd19, 3, 1, -99,   0,  -99, 0);
    add(8'd9,  3, 1, -99,   9,  -90, 0);
    add(8'd9,  3, 1, -99,  99,    0, 0);
    add(8'd12, 3, 1, -99, -99, -198, 0);
    add(8'd26, 1, 1, -99, -99, -198, 0);
    add(8'd30, 1, 1, -99, -99,    0, 1);
    add(8'd15, 2, 1,   0, -99,   99, 1);
    add(8'd0,  2, 1,   0, -99,   99, 1);
    add(8'd12, 2, 1,   0, -99,   99, 1);
    add(8'd20, 2, 1,   0, -99,   99, 1);
    add(8'd16, 1, 1,   0,   0,    0, 0);
    add(8'd7,  1, 1,   0,   0,    0, 0);
    add(8'd12, 1, 1,   0,   0,    0, 0);
    add(8'd15, 2, 1,   0,   0,    0, 0);
    add(8'd5,  2, 1,   5,   0,    5, 0);
    add(8'd18, 0, 0,   0,   0,    0, 0);
    add(8'd15, 0, 0,   0,   0,    0, 0);
    add(8'd18, 1, 1,   0,   0,    0, 0);

    bus.validate = 1'b0;
    bus.data     = 8'd0;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("rst_mode", int'(bus.mode), 0);
    chk("rst_on", int'(bus.ON), 0);
    chk("rst_value", sv(), 0);
    RESET_N = 1'b1;
    repeat (3) @(posedge CLOCK_50);

    for (int i = 0; i < vecs.size(); i++) begin
      sb.push_back(vecs[i]);
      press(vecs[i].key);
      if (sb.size() == 0) begin
        chk($sformatf("sb_empty_%0d", i), 0, 1);
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d_mode", i), int'(bus.mode), e.mode);
        chk($sformatf("v%0d_on", i), int'(bus.ON), e.on);
        chk($sformatf("v%0d_A", i), sa(), e.a);
        chk($sformatf("v%0d_B", i), sbv(), e.b);
        chk($sformatf("v%0d_value", i), sv(), e.val);
        chk($sformatf("v%0d_opsub", i), int'(bus.op_sub), e.sub);
      end
    end

    // Latency and held strobe: one digit per validate pulse, value trails out_A by one edge.
    press(8'd15);
    chk("held_mode", int'(bus.mode), 2);
    @(negedge CLOCK_50);
    bus.data     = 8'd3;
    bus.validate = 1'b1;
    repeat (2) @(posedge CLOCK_50);
    #1 chk("lat_e2_A", sa(), 0);
    @(posedge CLOCK_50);
    #1 chk("lat_e3_A", sa(), 3);
    chk("lat_e3_value", sv(), 0);
    @(posedge CLOCK_50);
    #1 chk("lat_e4_value", sv(), 3);
    repeat (100) @(posedge CLOCK_50);
    #1 chk("held_A", sa(), 3);
    @(negedge CLOCK_50);
    bus.validate = 1'b0;
    repeat (4) @(posedge CLOCK_50);

    // Reset mid-entry with validate (K_ONOFF) held across release.
    @(negedge CLOCK_50);
    bus.data     = 8'd18;
    bus.validate = 1'b1;
    repeat (2) @(posedge CLOCK_50);
    #3 RESET_N = 1'b0;
    #1;
    chk("arst_mode", int'(bus.mode), 0);
    chk("arst_on", int'(bus.ON), 0);
    chk("arst_A", sa(), 0);
    chk("arst_value", sv(), 0);
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    repeat (20) @(posedge CLOCK_50);
    #1 chk("arst_nokey_mode", int'(bus.mode), 0);
    chk("arst_nokey_on", int'(bus.ON), 0);
    @(negedge CLOCK_50);
    bus.validate = 1'b0;
    repeat (4) @(posedge CLOCK_50);
    press(8'd18);
    chk("post_rst_on", int'(bus.ON), 1);
    chk("post_rst_mode", int'(bus.mode), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
